// File: rtl/my_package_pkg.sv
// Shared types for the ring-FSM observer: the observed ring state encoding,
// the tracker state set and a small ring-arithmetic helper.
package my_package_pkg;

    typedef enum logic [2:0] {
        FSM_ST0 = 3'd0,
        FSM_ST1 = 3'd1,
        FSM_ST2 = 3'd2,
        FSM_ST3 = 3'd3,
        FSM_ST4 = 3'd4,
        FSM_ST5 = 3'd5,
        FSM_ST6 = 3'd6,
        FSM_ST7 = 3'd7
    } FSM_States_t;

    typedef enum logic [1:0] {
        TRK_IDLE = 2'd0,
        TRK_ACQ  = 2'd1,
        TRK_LOCK = 2'd2,
        TRK_ERR  = 2'd3
    } tracker_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Ring positions are 3 bits wide, so plain addition wraps modulo 8.
    function automatic logic [2:0] ring_offset(input logic [2:0] base, input logic [2:0] delta);
        return base + delta;
    endfunction

endpackage

// File: rtl/fsm_step_classify.sv
// Combinational classifier: compares the current ring sample with the previous
// one and reports a +1 step, a -1 step, or anything else (including hold).
module fsm_step_classify
    import my_package_pkg::*;
(
    input  FSM_States_t prev,
    input  FSM_States_t cur,
    output logic        up,
    output logic        dn,
    output logic        illegal
);

    logic [2:0] prev_s;
    logic [2:0] cur_s;

    assign prev_s = prev;
    assign cur_s  = cur;

    // Step classification; a delta of 7 is a -1 step on the ring.
    always_comb begin
        up      = (cur_s == ring_offset(prev_s, 3'd1));
        dn      = (cur_s == ring_offset(prev_s, 3'd7));
        illegal = ~(up | dn);
    end

endmodule

// File: rtl/fsm_state_tracker.sv
// Tracks an observed ring FSM: acquires lock after LOCK_COUNT consecutive legal
// steps, then reports step pulses, a signed position and illegal-step errors.
module fsm_state_tracker
    import my_package_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned POS_W      = 16
) (
    input  logic                    c,
    input  logic                    rst,
    input  logic                    vld,
    input  FSM_States_t             state_in,
    output logic                    locked,
    output logic                    step_up,
    output logic                    step_dn,
    output logic                    err,
    output logic [7:0]              err_cnt,
    output logic signed [POS_W-1:0] pos,
    output FSM_States_t             last_state
);

    localparam logic [3:0]       LOCK_CNT_L = 4'(LOCK_COUNT);
    localparam logic [POS_W-1:0] POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0] POS_ZERO   = {POS_W{1'b0}};

    tracker_state_t          state_r,   state_nxt_s;
    logic [3:0]              good_r,    good_nxt_s;
    logic [POS_W-1:0]        pos_r,     pos_nxt_s;
    logic [7:0]              err_cnt_r, err_cnt_nxt_s;
    FSM_States_t             prev_r,    prev_nxt_s;
    logic                    locked_r,  locked_nxt_s;
    logic                    up_r,      up_nxt_s;
    logic                    dn_r,      dn_nxt_s;
    logic                    err_r,     err_nxt_s;
    logic                    up_s, dn_s, illegal_s;

    fsm_step_classify u_classify (
        .prev    (prev_r),
        .cur     (state_in),
        .up      (up_s),
        .dn      (dn_s),
        .illegal (illegal_s)
    );

    // State, counters and registered outputs; reset wins over any sample.
    always_ff @(posedge c) begin
        if (rst) begin
            state_r   <= TRK_IDLE;
            good_r    <= 4'd0;
            pos_r     <= POS_ZERO;
            err_cnt_r <= 8'd0;
            prev_r    <= FSM_ST0;
            locked_r  <= 1'b0;
            up_r      <= 1'b0;
            dn_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            good_r    <= good_nxt_s;
            pos_r     <= pos_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
            prev_r    <= prev_nxt_s;
            locked_r  <= locked_nxt_s;
            up_r      <= up_nxt_s;
            dn_r      <= dn_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    // Next-state, counter and pulse logic.
    always_comb begin
        state_nxt_s   = state_r;
        good_nxt_s    = good_r;
        pos_nxt_s     = pos_r;
        err_cnt_nxt_s = err_cnt_r;
        prev_nxt_s    = vld ? state_in : prev_r;
        up_nxt_s      = 1'b0;
        dn_nxt_s      = 1'b0;
        err_nxt_s     = 1'b0;

        case (state_r)
            TRK_IDLE: begin
                if (vld) begin
                    state_nxt_s = TRK_ACQ;
                    good_nxt_s  = 4'd0;
                end else begin
                    state_nxt_s = TRK_IDLE;
                end
            end
            TRK_ACQ: begin
                if (!vld) begin
                    state_nxt_s = TRK_ACQ;
                end else if (illegal_s) begin
                    good_nxt_s = 4'd0;
                end else if ((good_r + 4'd1) == LOCK_CNT_L) begin
                    good_nxt_s  = LOCK_CNT_L;
                    state_nxt_s = TRK_LOCK;
                end else begin
                    good_nxt_s = good_r + 4'd1;
                end
            end
            TRK_LOCK: begin
                if (!vld) begin
                    state_nxt_s = TRK_LOCK;
                end else if (up_s) begin
                    up_nxt_s  = 1'b1;
                    pos_nxt_s = pos_r + POS_ONE;
                end else if (dn_s) begin
                    dn_nxt_s  = 1'b1;
                    pos_nxt_s = pos_r - POS_ONE;
                end else begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = TRK_ERR;
                    if (err_cnt_r != ERR_CNT_MAX) begin
                        err_cnt_nxt_s = err_cnt_r + 8'd1;
                    end else begin
                        err_cnt_nxt_s = err_cnt_r;
                    end
                end
            end
            // Recovery cycle: leaves unconditionally, samples only refresh prev.
            TRK_ERR: begin
                state_nxt_s = TRK_ACQ;
                good_nxt_s  = 4'd0;
            end
            default: begin
                state_nxt_s = TRK_IDLE;
                good_nxt_s  = 4'd0;
            end
        endcase

        locked_nxt_s = (state_nxt_s == TRK_LOCK);
    end

    assign locked     = locked_r;
    assign step_up    = up_r;
    assign step_dn    = dn_r;
    assign err        = err_r;
    assign err_cnt    = err_cnt_r;
    assign pos        = pos_r;
    assign last_state = prev_r;

endmodule

// File: tb/tb_fsm_state_tracker.sv
// Scoreboard bench for fsm_state_tracker: a driver feeds directed and random
// samples into a ring-step reference model; a monitor checks every cycle.
module tb_fsm_state_tracker;
    import my_package_pkg::*;

    localparam int LOCK_N = 4;
    localparam int MD_IDLE = 0, MD_ACQ = 1, MD_LOCK = 2, MD_ERR = 3;

    typedef struct packed {
        logic        locked;
        logic        up;
        logic        dn;
        logic        err;
        logic [7:0]  errc;
        logic [15:0] pos;
        logic [2:0]  last;
    } exp_t;

    logic        c = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    FSM_States_t state_in = FSM_ST0;
    logic        locked, step_up, step_dn, err;
    logic [7:0]  err_cnt;
    logic signed [15:0] pos;
    FSM_States_t last_state;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    int       m_mode = MD_IDLE;
    int       m_good = 0;
    int       m_pos = 0;
    int       m_errc = 0;
    logic [2:0] m_last = 3'd0;

    fsm_state_tracker #(.LOCK_COUNT(LOCK_N), .POS_W(16)) dut (
        .c          (c),
        .rst        (rst),
        .vld        (vld),
        .state_in   (state_in),
        .locked     (locked),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .err        (err),
        .err_cnt    (err_cnt),
        .pos        (pos),
        .last_state (last_state)
    );

    always #5 c = ~c;

    task automatic model_step(input logic r, input logic v, input logic [2:0] s);
        exp_t e;
        int   d;
        e = '0;
        if (r) begin
            m_mode = MD_IDLE; m_good = 0; m_pos = 0; m_errc = 0; m_last = 3'd0;
        end else if (m_mode == MD_ERR) begin
            m_mode = MD_ACQ; m_good = 0;
            if (v) m_last = s;
        end else if (v) begin
            d = (int'(s) - int'(m_last) + 8) % 8;
            if (m_mode == MD_IDLE) begin
                m_mode = MD_ACQ; m_good = 0;
            end else if (m_mode == MD_ACQ) begin
                if (d == 1 || d == 7) begin
                    m_good = m_good + 1;
                    if (m_good == LOCK_N) m_mode = MD_LOCK;
                end else begin
                    m_good = 0;
                end
            end else begin
                if (d == 1) begin
                    e.up = 1'b1; m_pos = m_pos + 1;
                end else if (d == 7) begin
                    e.dn = 1'b1; m_pos = m_pos - 1;
                end else begin
                    e.err = 1'b1; m_mode = MD_ERR;
                    m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                end
            end
            m_last = s;
        end
        e.locked = (m_mode == MD_LOCK);
        e.errc   = 8'(m_errc);
        e.pos    = 16'(m_pos);
        e.last   = m_last;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] s);
        @(negedge c);
        rst = r;
        vld = v;
        state_in = FSM_States_t'(s);
        model_step(r, v, s);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock edge after it has been issued.
    always @(posedge c) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked",     {31'd0, locked},  {31'd0, e.locked});
            check("step_up",    {31'd0, step_up}, {31'd0, e.up});
            check("step_dn",    {31'd0, step_dn}, {31'd0, e.dn});
            check("err",        {31'd0, err},     {31'd0, e.err});
            check("err_cnt",    {24'd0, err_cnt}, {24'd0, e.errc});
            check("pos",        {16'd0, pos},     {16'd0, e.pos});
            check("last_state", {29'd0, 3'(last_state)}, {29'd0, e.last});
        end
    end

    task automatic relock();
        for (int k = 0; k < 20 && m_mode != MD_LOCK; k++) drive(1'b0, 1'b1, 3'(m_last + 3'd1));
    endtask

    initial begin
        logic [2:0] s;
        int r;
        drive(1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 3'd5);
        // Acquire: 0..4, then locked up-steps including the 7->0 wrap
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 3'(i));
        for (int i = 5; i < 9; i++) drive(1'b0, 1'b1, 3'(i));
        // Hold while locked, sample during ERR, then relock with 4 steps
        drive(1'b0, 1'b1, 3'd1);
        drive(1'b0, 1'b1, 3'd1);
        drive(1'b0, 1'b1, 3'd2);
        for (int i = 3; i < 7; i++) drive(1'b0, 1'b1, 3'(i));
        // Gap of 10 idle cycles, then the next legal value
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 3'd3);
        drive(1'b0, 1'b1, 3'd7);
        drive(1'b0, 1'b1, 3'd6);
        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      s = 3'(m_last + 3'd1);
            else if (r < 8) s = 3'(m_last - 3'd1);
            else            s = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), s);
        end
        // err_cnt saturation
        drive(1'b1, 1'b0, 3'd0);
        for (int n = 0; n < 300; n++) begin
            relock();
            drive(1'b0, 1'b1, m_last);
        end
        // Reset while locked with pos = 7
        drive(1'b1, 1'b0, 3'd0);
        relock();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 3'(m_last + 3'd1));
        drive(1'b1, 1'b1, 3'(m_last + 3'd1));
        drive(1'b0, 1'b0, 3'd0);
        // Two's complement wrap of pos
        relock();
        for (int i = 0; i < 32768; i++) drive(1'b0, 1'b1, 3'(m_last + 3'd1));
        drive(1'b0, 1'b1, 3'(m_last - 3'd1));
        drive(1'b0, 1'b1, 3'(m_last + 3'd1));
        drive(1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge c);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
